// File: rtl/sha2_w_expander_stream.sv
// Streaming SHA-2 message-schedule expander.
// Accepts one 16-word block and emits W0..W(NUM_W-1), one word per handshake.
// WIDTH=32 gives the SHA-256 schedule (64 words) and enables the double-SHA256
// padding modes. WIDTH=64 gives the SHA-512 schedule (80 words) and ignores mode.
module sha2_w_expander_stream #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [16*WIDTH-1:0]  block_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_w,
    output logic [6:0]           out_idx,
    output logic                 out_last,
    output logic                 busy
);

    localparam int         NUM_W    = (WIDTH == 64) ? 80 : 64;
    localparam logic [6:0] LAST_IDX = 7'(NUM_W - 1);

    // Rotation / shift amounts of the small sigma functions for each word size.
    localparam int S0_R1 = (WIDTH == 64) ? 1  : 7;
    localparam int S0_R2 = (WIDTH == 64) ? 8  : 18;
    localparam int S0_SH = (WIDTH == 64) ? 7  : 3;
    localparam int S1_R1 = (WIDTH == 64) ? 19 : 17;
    localparam int S1_R2 = (WIDTH == 64) ? 61 : 19;
    localparam int S1_SH = (WIDTH == 64) ? 6  : 10;

    // Constant words of the double-SHA256 padding (only used when WIDTH=32).
    localparam logic [WIDTH-1:0] PAD_ONE    = WIDTH'(32'h8000_0000);
    localparam logic [WIDTH-1:0] LEN_DIGEST = WIDTH'(32'h0000_0100);
    localparam logic [WIDTH-1:0] LEN_TAIL   = WIDTH'(32'h0000_0280);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] win [16];
    logic [6:0]       idx;
    logic [WIDTH-1:0] next_w;
    logic             load;
    logic             advance;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        logic [2*WIDTH-1:0] d;
        d = {x, x} >> n;
        return d[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sig0(input logic [WIDTH-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WIDTH-1:0] sig1(input logic [WIDTH-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // Word i of a freshly loaded window, with padding words substituted by mode.
    function automatic logic [WIDTH-1:0] load_word(input int i,
                                                   input logic [16*WIDTH-1:0] blk,
                                                   input logic [1:0] m);
        logic [WIDTH-1:0] w;
        w = blk[(15 - i)*WIDTH +: WIDTH];
        if (WIDTH == 32) begin
            if (m == 2'd1 && i >= 8)
                w = (i == 8) ? PAD_ONE : ((i == 15) ? LEN_DIGEST : '0);
            else if (m == 2'd2 && i >= 4)
                w = (i == 4) ? PAD_ONE : ((i == 15) ? LEN_TAIL : '0);
        end
        return w;
    endfunction

    assign out_valid = (state == S_EMIT);
    assign busy      = (state == S_EMIT);
    assign out_w     = win[0];
    assign out_idx   = idx;
    assign out_last  = (state == S_EMIT) && (idx == LAST_IDX);
    assign in_ready  = (state == S_IDLE) || (out_last && out_ready);
    assign load      = in_valid && in_ready;
    assign advance   = out_valid && out_ready;

    // Schedule recurrence producing the word that enters the top of the window.
    always_comb begin
        next_w = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end

    // Window, index and FSM: load wins over advance so blocks chain with no bubble.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            idx   <= '0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (load) begin
            state <= S_EMIT;
            idx   <= '0;
            for (int i = 0; i < 16; i++) win[i] <= load_word(i, block_in, mode);
        end else if (advance) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= next_w;
            idx     <= idx + 7'd1;
            if (out_last) state <= S_IDLE;
        end
    end

endmodule
